// File: rtl/fp64_mul_seq_ctrl_if.sv
// Operand/result handshake bundle for the sequenced binary64 multiplier.
// The master side issues operand pairs and accepts results; the slave side
// is the multiplier controller.
interface fp64_mul_seq_ctrl_if;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] a;
  logic [63:0] b;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] result;
  logic        overflow;
  logic        underflow;
  logic        invalid;

  modport master (
    output in_valid, a, b, out_ready,
    input  in_ready, out_valid, result, overflow, underflow, invalid
  );

  modport slave (
    input  in_valid, a, b, out_ready,
    output in_ready, out_valid, result, overflow, underflow, invalid
  );
endinterface

// File: rtl/fp64_mul_seq_ctrl.sv
// Sequenced binary64 multiplier controller. Special operands (NaN, inf,
// zero/denormal) are resolved in one CHECK cycle. Normal operands build the
// 106-bit mantissa product with one gated partial-product add per multiplier
// bit (53 ITER cycles), then normalize with truncation and pack.
module fp64_mul_seq_ctrl (
  input  logic                 clk,
  input  logic                 rst,
  fp64_mul_seq_ctrl_if.slave   bus
);

  typedef enum logic [2:0] {IDLE, CHECK, ITER, NORM, DONE} state_t;

  state_t        state_reg;
  logic [62:0]   a_reg;
  logic [62:0]   b_reg;
  logic          sign_reg;
  logic [52:0]   ma_reg;
  logic [52:0]   mb_reg;
  logic [106:0]  acc_reg;
  logic [5:0]    cnt_reg;
  logic [63:0]   result_reg;
  logic          overflow_reg;
  logic          underflow_reg;
  logic          invalid_reg;
  logic          out_valid_reg;

  // Operand classification from the captured operands.
  logic exp_a_max, exp_b_max, frac_a_nz, frac_b_nz;
  logic nan_a, nan_b, inf_a, inf_b, zero_a, zero_b;
  logic invalid_case, inf_case, zero_case;

  assign exp_a_max    = &a_reg[62:52];
  assign exp_b_max    = &b_reg[62:52];
  assign frac_a_nz    = |a_reg[51:0];
  assign frac_b_nz    = |b_reg[51:0];
  assign nan_a        = exp_a_max & frac_a_nz;
  assign nan_b        = exp_b_max & frac_b_nz;
  assign inf_a        = exp_a_max & ~frac_a_nz;
  assign inf_b        = exp_b_max & ~frac_b_nz;
  assign zero_a       = ~|a_reg[62:52];
  assign zero_b       = ~|b_reg[62:52];
  assign invalid_case = nan_a | nan_b | (inf_a & zero_b) | (inf_b & zero_a);
  assign inf_case     = inf_a | inf_b;
  assign zero_case    = zero_a | zero_b;

  // Gated partial product: the multiplier is shifted right each step so its
  // LSB is always the gate for the current bit.
  logic        gate;
  logic [52:0] gated;

  assign gate = mb_reg[0];

  genvar gi;
  generate
    for (gi = 0; gi < 53; gi++) begin : g_gate
      assign gated[gi] = ma_reg[gi] & gate;
    end
  endgenerate

  // One shift-add step: add the partial product at bit 53, shift right one.
  logic [54:0]  acc_sum;
  logic [106:0] acc_next;

  assign acc_sum  = {1'b0, acc_reg[106:53]} + {2'b00, gated};
  assign acc_next = {acc_sum, acc_reg[52:1]};

  // Normalization of the finished product p = acc[105:0], truncating.
  logic [12:0] e_base;
  logic [12:0] e_norm;
  logic        p_top;
  logic [51:0] frac_norm;

  assign e_base    = {2'b00, a_reg[62:52]} + {2'b00, b_reg[62:52]} - 13'd1023;
  assign p_top     = acc_reg[105];
  assign e_norm    = e_base + {12'd0, p_top};
  assign frac_norm = p_top ? acc_reg[104:53] : acc_reg[103:52];

  // Control FSM with registered result, flags and valid.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      a_reg         <= '0;
      b_reg         <= '0;
      sign_reg      <= 1'b0;
      ma_reg        <= '0;
      mb_reg        <= '0;
      acc_reg       <= '0;
      cnt_reg       <= '0;
      result_reg    <= '0;
      overflow_reg  <= 1'b0;
      underflow_reg <= 1'b0;
      invalid_reg   <= 1'b0;
      out_valid_reg <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (bus.in_valid) begin
            a_reg         <= bus.a[62:0];
            b_reg         <= bus.b[62:0];
            sign_reg      <= bus.a[63] ^ bus.b[63];
            overflow_reg  <= 1'b0;
            underflow_reg <= 1'b0;
            invalid_reg   <= 1'b0;
            state_reg     <= CHECK;
          end
        end
        CHECK: begin
          if (invalid_case) begin
            result_reg  <= 64'h7FF8_0000_0000_0000;
            invalid_reg <= 1'b1;
            state_reg   <= DONE;
          end else if (inf_case) begin
            result_reg <= {sign_reg, 11'h7FF, 52'd0};
            state_reg  <= DONE;
          end else if (zero_case) begin
            result_reg <= {sign_reg, 63'd0};
            state_reg  <= DONE;
          end else begin
            ma_reg    <= {1'b1, a_reg[51:0]};
            mb_reg    <= {1'b1, b_reg[51:0]};
            acc_reg   <= '0;
            cnt_reg   <= '0;
            state_reg <= ITER;
          end
        end
        ITER: begin
          acc_reg <= acc_next;
          mb_reg  <= {1'b0, mb_reg[52:1]};
          cnt_reg <= cnt_reg + 6'd1;
          if (cnt_reg == 6'd52) begin
            state_reg <= NORM;
          end
        end
        NORM: begin
          if ($signed(e_norm) >= $signed(13'd2047)) begin
            result_reg   <= {sign_reg, 11'h7FF, 52'd0};
            overflow_reg <= 1'b1;
          end else if ($signed(e_norm) <= $signed(13'd0)) begin
            result_reg    <= {sign_reg, 63'd0};
            underflow_reg <= 1'b1;
          end else begin
            result_reg <= {sign_reg, e_norm[10:0], frac_norm};
          end
          state_reg <= DONE;
        end
        DONE: begin
          if (!out_valid_reg) begin
            out_valid_reg <= 1'b1;
          end else if (bus.out_ready) begin
            out_valid_reg <= 1'b0;
            state_reg     <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = (state_reg == IDLE) && !rst;
  assign bus.out_valid = out_valid_reg;
  assign bus.result    = result_reg;
  assign bus.overflow  = overflow_reg;
  assign bus.underflow = underflow_reg;
  assign bus.invalid   = invalid_reg;

endmodule
